movwide_splitter: RTL

Inverse of the wide-immediate shifter: takes a 64-bit constant and emits the MOVZ/MOVK (optionally MOVN) instruction sequence that rebuilds it, as (imm16, hw, op) chunks, one per handshake.
Sits between the constant-materialisation logic of the instruction generator/test stimulus path and the instruction encoder.
Each emitted chunk, applied in order through the shifter and register-keep path, reproduces the input value exactly.

---
 rtl/movwide_pkg.sv | 24 ++
 rtl/movwide_chunk_pick.sv | 31 +++
 rtl/movwide_splitter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/movwide_pkg.sv
// Shared definitions for the MOV-wide constant splitter: op encodings,
// chunk geometry, FSM state type and a halfword extraction helper.
package movwide_pkg;

  localparam int unsigned CHUNK_W    = 16;
  localparam int unsigned NUM_CHUNKS = 4;
  localparam int unsigned HW_W       = $clog2(NUM_CHUNKS);
  localparam int unsigned VALUE_W    = CHUNK_W * NUM_CHUNKS;

  localparam logic [1:0] OP_MOVZ = 2'b00;
  localparam logic [1:0] OP_MOVN = 2'b01;
  localparam logic [1:0] OP_MOVK = 2'b10;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  function automatic logic [CHUNK_W-1:0] get_half(input logic [VALUE_W-1:0] v,
                                                  input logic [HW_W-1:0]    idx);
    return v[idx*CHUNK_W +: CHUNK_W];
  endfunction

endpackage

// File: rtl/movwide_chunk_pick.sv
// Combinational priority picker: finds the lowest pending halfword at or above
// (incl=1) or strictly above (incl=0) cur, and flags whether it is the final one.
module movwide_chunk_pick
  import movwide_pkg::*;
(
  input  logic [NUM_CHUNKS-1:0] mask,
  input  logic [HW_W-1:0]       cur,
  input  logic                  incl,
  output logic [HW_W-1:0]       nxt,
  output logic                  found,
  output logic                  is_last
);

  // Scan from the top so the last hit is the lowest index; any earlier hit
  // means another chunk remains above it.
  always_comb begin
    nxt     = '0;
    found   = 1'b0;
    is_last = 1'b1;
    for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        if (found) begin
          is_last = 1'b0;
        end
        found = 1'b1;
        nxt   = HW_W'(i);
      end
    end
  end

endmodule

// File: rtl/movwide_splitter.sv
// Splits a 64-bit constant into a MOVZ/MOVK (or MOVN/MOVK) chunk sequence.
// Optional MOVN selection is enabled by defining MOVN_OPT_EN.
module movwide_splitter
  import movwide_pkg::*;
#(
  parameter int unsigned SKIP_ZERO = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHUNK_W-1:0] out_imm16,
  output logic [HW_W-1:0]    out_hw,
  output logic [1:0]         out_op,
  output logic               out_last,
  output logic               busy
);

  state_e              state_q, state_d;
  logic [VALUE_W-1:0]  value_q, value_d;
  logic [NUM_CHUNKS-1:0] mask_q, mask_d;
  logic                valid_q, valid_d;
  logic [CHUNK_W-1:0]  imm_q, imm_d;
  logic [HW_W-1:0]     hw_q, hw_d;
  logic [1:0]          op_q, op_d;
  logic                last_q, last_d;

  logic                  movn_mode;
  logic [NUM_CHUNKS-1:0] acc_mask;
  logic [NUM_CHUNKS-1:0] pick_mask;
  logic [HW_W-1:0]       pick_cur, pick_nxt;
  logic                  pick_incl, pick_found, pick_last;
  logic [HW_W-1:0]       first_hw;
  logic [CHUNK_W-1:0]    first_half;

`ifdef MOVN_OPT_EN
  logic [HW_W:0] ones_cnt, zero_cnt;

  always_comb begin
    ones_cnt = '0;
    zero_cnt = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (in_value[i*CHUNK_W +: CHUNK_W] == '1) ones_cnt = ones_cnt + 1'b1;
      if (in_value[i*CHUNK_W +: CHUNK_W] == '0) zero_cnt = zero_cnt + 1'b1;
    end
  end

  // Ties stay in MOVZ mode.
  assign movn_mode = (ones_cnt > zero_cnt);
`else
  assign movn_mode = 1'b0;
`endif

  // Halfwords equal to the background pattern need no chunk of their own.
  always_comb begin
    acc_mask = '1;
    if (SKIP_ZERO != 0) begin
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        acc_mask[i] = movn_mode ? (in_value[i*CHUNK_W +: CHUNK_W] != '1)
                                : (in_value[i*CHUNK_W +: CHUNK_W] != '0);
      end
    end
  end

  assign pick_mask = (state_q == IDLE) ? acc_mask : mask_q;
  assign pick_cur  = (state_q == IDLE) ? '0 : hw_q;
  assign pick_incl = (state_q == IDLE);

  movwide_chunk_pick u_pick (
    .mask    (pick_mask),
    .cur     (pick_cur),
    .incl    (pick_incl),
    .nxt     (pick_nxt),
    .found   (pick_found),
    .is_last (pick_last)
  );

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    mask_d     = mask_q;
    valid_d    = valid_q;
    imm_d      = imm_q;
    hw_d       = hw_q;
    op_d       = op_q;
    last_d     = last_q;
    first_hw   = pick_found ? pick_nxt : '0;
    first_half = get_half(in_value, first_hw);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          value_d = in_value;
          mask_d  = acc_mask;
          valid_d = 1'b1;
          hw_d    = first_hw;
          imm_d   = movn_mode ? ~first_half : first_half;
          op_d    = movn_mode ? OP_MOVN : OP_MOVZ;
          // Nothing pending means all-zero (or all-ones in MOVN mode): one chunk.
          last_d  = pick_found ? pick_last : 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            mask_d  = '0;
            valid_d = 1'b0;
            imm_d   = '0;
            hw_d    = '0;
            op_d    = OP_MOVZ;
            last_d  = 1'b0;
          end else begin
            hw_d   = pick_nxt;
            imm_d  = get_half(value_q, pick_nxt);
            op_d   = OP_MOVK;
            last_d = pick_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      value_q <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      imm_q   <= '0;
      hw_q    <= '0;
      op_q    <= OP_MOVZ;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      imm_q   <= imm_d;
      hw_q    <= hw_d;
      op_q    <= op_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_imm16 = imm_q;
  assign out_hw    = hw_q;
  assign out_op    = op_q;
  assign out_last  = last_q;

endmodule
